writeback_unit: RTL and testbench

- Parametrised writeback stage between the execute/memory stages and the register file.
- Accepts one execute-stage bundle at a time over a valid/ready handshake.
- ALU results are committed directly. Load results wait for a memory response, are aligned by byte offset, then sign- or zero-extended.
- Drives a registered one-cycle register-file write pulse and a pending-load scoreboard for hazard logic. Timeout, misalignment and unexpected-response conditions are recorded in sticky error flags.

---
 rtl/writeback_unit.sv | 185 ++++++++++++++++++
 tb/tb_writeback_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_unit.sv
// Writeback stage: commits ALU results and aligned/extended load data to the register file.
// Latency: ALU 1 cycle after accept; load 1 cycle after mem_rsp_valid.
// Backpressure: in_ready is low for the whole time a load is outstanding (WAIT_MEM).
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   in_valid/in_ready + in_*        execute bundle handshake and payload
//   mem_rsp_valid, mem_rdata        memory read response
//   rf_we, rf_waddr, rf_wdata       registered one-cycle register-file write
//   pend_valid, pend_dest           outstanding-load scoreboard for hazard logic
//   err_timeout/misalign/unexp_rsp  sticky error flags, cleared only by reset
module writeback_unit #(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 3,
  parameter int TIMEOUT_CYC = 64,
  parameter int ZERO_REG_EN = 0,
  localparam int OFF_W      = $clog2(DATA_W / 8)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_dest,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_reg_write,
  input  logic              in_mem_read,
  input  logic [1:0]        in_ld_size,
  input  logic              in_ld_signed,
  input  logic [OFF_W-1:0]  in_ld_off,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              pend_valid,
  output logic [REG_AW-1:0] pend_dest,
  output logic              err_timeout,
  output logic              err_misalign,
  output logic              err_unexp_rsp
);

  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  // Last counter value of the wait window; reaching it without a response aborts.
  localparam int LIM   = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

  typedef enum logic {S_IDLE, S_WAIT_MEM} state_t;

  state_t              state_q;
  logic [REG_AW-1:0]   dest_q;
  logic [1:0]          size_q;
  logic                signed_q;
  logic [OFF_W-1:0]    off_q;
  logic                regw_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                rf_we_q;
  logic [REG_AW-1:0]   rf_waddr_q;
  logic [DATA_W-1:0]   rf_wdata_q;
  logic                err_timeout_q;
  logic                err_misalign_q;
  logic                err_unexp_q;

  logic                misalign_d;
  logic                alu_we_d;
  logic                ld_we_d;
  logic [DATA_W-1:0]   shifted_d;
  logic [DATA_W-1:0]   keep_mask_d;
  logic                sign_bit_d;
  logic [DATA_W-1:0]   ld_data_d;

  always_comb begin
    misalign_d = 1'b0;
    case (in_ld_size)
      2'b01:   misalign_d = in_ld_off[0];
      2'b10:   misalign_d = (in_ld_off[1:0] != 2'b00);
      2'b11:   misalign_d = (in_ld_off != '0);
      default: misalign_d = 1'b0;
    endcase
  end

  assign alu_we_d = in_reg_write & ~((ZERO_REG_EN != 0) & (in_dest == '0));
  assign ld_we_d  = regw_q & ~((ZERO_REG_EN != 0) & (dest_q == '0));

  // Load alignment: bring the addressed byte lane to bit 0, keep the access
  // width, then fill the upper bits with the sign bit or zeros. Size 11 keeps
  // the full datapath, which on a 32-bit build is identical to size 10.
  always_comb begin
    shifted_d   = mem_rdata >> {off_q, 3'b000};
    keep_mask_d = '1;
    sign_bit_d  = shifted_d[DATA_W-1];
    case (size_q)
      2'b00: begin
        keep_mask_d = DATA_W'(8'hFF);
        sign_bit_d  = shifted_d[7];
      end
      2'b01: begin
        keep_mask_d = DATA_W'(16'hFFFF);
        sign_bit_d  = shifted_d[15];
      end
      2'b10: begin
        keep_mask_d = DATA_W'(32'hFFFF_FFFF);
        sign_bit_d  = shifted_d[31];
      end
      default: begin
        keep_mask_d = '1;
        sign_bit_d  = shifted_d[DATA_W-1];
      end
    endcase
    ld_data_d = (shifted_d & keep_mask_d) |
                ({DATA_W{signed_q & sign_bit_d}} & ~keep_mask_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      dest_q         <= '0;
      size_q         <= '0;
      signed_q       <= 1'b0;
      off_q          <= '0;
      regw_q         <= 1'b0;
      cnt_q          <= '0;
      rf_we_q        <= 1'b0;
      rf_waddr_q     <= '0;
      rf_wdata_q     <= '0;
      err_timeout_q  <= 1'b0;
      err_misalign_q <= 1'b0;
      err_unexp_q    <= 1'b0;
    end else begin
      rf_we_q <= 1'b0;
      if (mem_rsp_valid && (state_q == S_IDLE)) begin
        err_unexp_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            if (!in_mem_read) begin
              rf_we_q    <= alu_we_d;
              rf_waddr_q <= in_dest;
              rf_wdata_q <= in_result;
            end else if (misalign_d) begin
              // Bad load is consumed and dropped; stage stays available.
              err_misalign_q <= 1'b1;
            end else begin
              state_q  <= S_WAIT_MEM;
              dest_q   <= in_dest;
              size_q   <= in_ld_size;
              signed_q <= in_ld_signed;
              off_q    <= in_ld_off;
              regw_q   <= in_reg_write;
              cnt_q    <= '0;
            end
          end
        end
        S_WAIT_MEM: begin
          // A response on the limit cycle takes priority over the timeout.
          if (mem_rsp_valid) begin
            rf_we_q    <= ld_we_d;
            rf_waddr_q <= dest_q;
            rf_wdata_q <= ld_data_d;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
          end else if ((TIMEOUT_CYC != 0) && (cnt_q == CNT_W'(LIM))) begin
            err_timeout_q <= 1'b1;
            state_q       <= S_IDLE;
            cnt_q         <= '0;
          end else if (TIMEOUT_CYC != 0) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // in_ready is held low while reset is asserted.
  assign in_ready      = (state_q == S_IDLE) & rst_n;
  assign pend_valid    = (state_q == S_WAIT_MEM);
  assign pend_dest     = pend_valid ? dest_q : '0;
  assign rf_we         = rf_we_q;
  assign rf_waddr      = rf_waddr_q;
  assign rf_wdata      = rf_wdata_q;
  assign err_timeout   = err_timeout_q;
  assign err_misalign  = err_misalign_q;
  assign err_unexp_rsp = err_unexp_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit with a write scoreboard.
// Two instances share stimulus: one with zero-register suppression off, one on.
// Register-file writes of the main instance are popped from the expected queue.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [2:0]  in_dest;
  logic [31:0] in_result;
  logic        in_reg_write;
  logic        in_mem_read;
  logic [1:0]  in_ld_size;
  logic        in_ld_signed;
  logic [1:0]  in_ld_off;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;

  logic        in_ready, rf_we, pend_valid, err_timeout, err_misalign, err_unexp_rsp;
  logic [2:0]  rf_waddr, pend_dest;
  logic [31:0] rf_wdata;

  logic        in_ready_z, rf_we_z, pend_valid_z, err_timeout_z, err_misalign_z, err_unexp_rsp_z;
  logic [2:0]  rf_waddr_z, pend_dest_z;
  logic [31:0] rf_wdata_z;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];

  always #5 clk = ~clk;

  writeback_unit #(.DATA_W(32), .REG_AW(3), .TIMEOUT_CYC(4), .ZERO_REG_EN(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_dest(in_dest), .in_result(in_result), .in_reg_write(in_reg_write),
    .in_mem_read(in_mem_read), .in_ld_size(in_ld_size), .in_ld_signed(in_ld_signed),
    .in_ld_off(in_ld_off), .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pend_valid(pend_valid), .pend_dest(pend_dest), .err_timeout(err_timeout),
    .err_misalign(err_misalign), .err_unexp_rsp(err_unexp_rsp)
  );

  writeback_unit #(.DATA_W(32), .REG_AW(3), .TIMEOUT_CYC(4), .ZERO_REG_EN(1)) dut_z (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_z),
    .in_dest(in_dest), .in_result(in_result), .in_reg_write(in_reg_write),
    .in_mem_read(in_mem_read), .in_ld_size(in_ld_size), .in_ld_signed(in_ld_signed),
    .in_ld_off(in_ld_off), .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .rf_we(rf_we_z), .rf_waddr(rf_waddr_z), .rf_wdata(rf_wdata_z),
    .pend_valid(pend_valid_z), .pend_dest(pend_dest_z), .err_timeout(err_timeout_z),
    .err_misalign(err_misalign_z), .err_unexp_rsp(err_unexp_rsp_z)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic drive_load(input logic [2:0] dest, input logic [1:0] size,
                            input logic sgn, input logic [1:0] off);
    in_valid     = 1'b1;
    in_mem_read  = 1'b1;
    in_reg_write = 1'b1;
    in_dest      = dest;
    in_ld_size   = size;
    in_ld_signed = sgn;
    in_ld_off    = off;
  endtask

  // Scoreboard: every write pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {29'd0, rf_waddr}, 32'hFFFF_FFFF);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        chk("wr_addr", {29'd0, rf_waddr}, {29'd0, w.addr});
        chk("wr_data", rf_wdata, w.data);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_dest = '0; in_result = '0; in_reg_write = 1'b0;
    in_mem_read = 1'b0; in_ld_size = '0; in_ld_signed = 1'b0; in_ld_off = '0;
    mem_rsp_valid = 1'b0; mem_rdata = '0;

    // Reset state
    #2;
    chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_pend", {31'd0, pend_valid}, 32'd0);
    chk("rst_errs", {29'd0, err_timeout, err_misalign, err_unexp_rsp}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // ALU back-to-back
    tick();
    in_valid = 1'b1; in_mem_read = 1'b0; in_reg_write = 1'b1;
    in_dest = 3'd3; in_result = 32'h1234_5678;
    push(3'd3, 32'h1234_5678);
    tick();
    chk("alu0_we", {31'd0, rf_we}, 32'd1);
    in_dest = 3'd5; in_result = 32'hCAFE_BABE;
    push(3'd5, 32'hCAFE_BABE);
    tick();
    chk("alu1_we", {31'd0, rf_we}, 32'd1);
    chk("alu1_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0;
    tick();

    // Signed byte load, response three cycles after accept
    drive_load(3'd2, 2'b00, 1'b1, 2'd2);
    tick();
    in_valid = 1'b0;
    chk("sb_pend", {31'd0, pend_valid}, 32'd1);
    chk("sb_pdest", {29'd0, pend_dest}, 32'd2);
    chk("sb_ready0", {31'd0, in_ready}, 32'd0);
    tick();
    chk("sb_ready1", {31'd0, in_ready}, 32'd0);
    tick();
    chk("sb_ready2", {31'd0, in_ready}, 32'd0);
    mem_rsp_valid = 1'b1; mem_rdata = 32'h00F3_0000;
    push(3'd2, 32'hFFFF_FFF3);
    tick();
    mem_rsp_valid = 1'b0;
    chk("sb_we", {31'd0, rf_we}, 32'd1);
    chk("sb_pend_clr", {31'd0, pend_valid}, 32'd0);
    chk("sb_ready_back", {31'd0, in_ready}, 32'd1);

    // Unsigned half at offset 2
    drive_load(3'd4, 2'b01, 1'b0, 2'd2);
    tick();
    in_valid = 1'b0;
    mem_rsp_valid = 1'b1; mem_rdata = 32'h8001_ABCD;
    push(3'd4, 32'h0000_8001);
    tick();
    mem_rsp_valid = 1'b0;

    // Signed half at offset 0
    drive_load(3'd1, 2'b01, 1'b1, 2'd0);
    tick();
    in_valid = 1'b0;
    mem_rsp_valid = 1'b1; mem_rdata = 32'h1234_F00F;
    push(3'd1, 32'hFFFF_F00F);
    tick();
    mem_rsp_valid = 1'b0;

    // Size 11 on a 32-bit build acts as a word load
    drive_load(3'd6, 2'b11, 1'b1, 2'd0);
    tick();
    in_valid = 1'b0;
    mem_rsp_valid = 1'b1; mem_rdata = 32'h8000_0001;
    push(3'd6, 32'h8000_0001);
    tick();
    mem_rsp_valid = 1'b0;

    // Misaligned half: flagged, no write, stage stays ready
    chk("pre_misalign", {31'd0, err_misalign}, 32'd0);
    drive_load(3'd6, 2'b01, 1'b0, 2'd1);
    tick();
    in_valid = 1'b0;
    chk("mis_flag", {31'd0, err_misalign}, 32'd1);
    chk("mis_ready", {31'd0, in_ready}, 32'd1);
    chk("mis_pend", {31'd0, pend_valid}, 32'd0);
    chk("mis_we", {31'd0, rf_we}, 32'd0);
    tick();

    // Response on the limit cycle wins over the timeout
    drive_load(3'd1, 2'b10, 1'b0, 2'd0);
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    mem_rsp_valid = 1'b1; mem_rdata = 32'h1122_3344;
    push(3'd1, 32'h1122_3344);
    tick();
    mem_rsp_valid = 1'b0;
    chk("lim_we", {31'd0, rf_we}, 32'd1);
    chk("lim_no_to", {31'd0, err_timeout}, 32'd0);

    // Timeout after four WAIT_MEM cycles, then an unexpected response
    drive_load(3'd7, 2'b10, 1'b0, 2'd0);
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    chk("to_not_yet", {31'd0, err_timeout}, 32'd0);
    chk("to_pend_wait", {31'd0, pend_valid}, 32'd1);
    tick();
    chk("to_flag", {31'd0, err_timeout}, 32'd1);
    chk("to_pend_clr", {31'd0, pend_valid}, 32'd0);
    chk("to_ready", {31'd0, in_ready}, 32'd1);
    chk("pre_unexp", {31'd0, err_unexp_rsp}, 32'd0);
    mem_rsp_valid = 1'b1; mem_rdata = 32'hDEAD_0000;
    tick();
    mem_rsp_valid = 1'b0;
    chk("unexp_flag", {31'd0, err_unexp_rsp}, 32'd1);
    chk("unexp_no_we", {31'd0, rf_we}, 32'd0);
    tick();
    chk("sticky_mis", {31'd0, err_misalign}, 32'd1);

    // Zero-register suppression
    in_valid = 1'b1; in_mem_read = 1'b0; in_reg_write = 1'b1;
    in_dest = 3'd0; in_result = 32'hDEAD_BEEF;
    push(3'd0, 32'hDEAD_BEEF);
    tick();
    chk("zr_off_we", {31'd0, rf_we}, 32'd1);
    chk("zr_on_we", {31'd0, rf_we_z}, 32'd0);
    in_dest = 3'd5; in_reg_write = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("noregw_we", {31'd0, rf_we}, 32'd0);
    tick();

    // Reset in the middle of a load
    drive_load(3'd3, 2'b00, 1'b0, 2'd0);
    tick();
    in_valid = 1'b0;
    chk("rl_pend", {31'd0, pend_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rl_pend_clr", {31'd0, pend_valid}, 32'd0);
    chk("rl_pdest_clr", {29'd0, pend_dest}, 32'd0);
    chk("rl_errs_clr", {29'd0, err_timeout, err_misalign, err_unexp_rsp}, 32'd0);
    chk("rl_ready_low", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rl_ready", {31'd0, in_ready}, 32'd1);
    tick(); tick();
    chk("rl_no_we", {31'd0, rf_we}, 32'd0);

    chk("sb_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
